// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU weight path: sequencer state encoding and block sizing.
package tpu_pkg;

  localparam int WEIGHT_BLOCK_SIZE = 16;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SWAP   = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;
  localparam logic [1:0] ST_DRAIN  = 2'd3;

endpackage

// File: rtl/valid_idx_delay.sv
// Fixed-depth shift register that aligns the read-enable/index tag with the buffer's data_out.
module valid_idx_delay
  import tpu_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             busy
);

  logic [WIDTH-1:0] pipe [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[DEPTH-1];

  // The MSB of each stage is the valid tag; any set bit means a beat is still in flight.
  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) busy = busy | pipe[i][WIDTH-1];
  end

endmodule

// File: rtl/weight_buffer_ctrl.sv
// Sequencer for the double-buffered weight_buffer: counts beats in, swaps full blocks,
// and streams one block out per array request with valid/index tagging.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_IDLE   | waiting: swap a full write block, or start streaming on tile_req
// ST_SWAP   | one-cycle swap pulse; read side becomes loaded
// ST_STREAM | issuing read_en for each beat of the loaded block
// ST_DRAIN  | last read issued; wait for its weight_valid, then tile_done
module weight_buffer_ctrl
  import tpu_pkg::*;
#(
  parameter int BLOCK_SIZE   = WEIGHT_BLOCK_SIZE,
  parameter int READ_LATENCY = 1,
  parameter int IDX_W        = $clog2(BLOCK_SIZE)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             src_valid,
  output logic             src_ready,
  output logic             buf_in_valid,
  input  logic             buf_in_ready,
  output logic             buf_swap,
  output logic             buf_read_en,
  input  logic             buf_empty,
  input  logic             tile_req,
  output logic             block_ready,
  output logic             weight_valid,
  output logic [IDX_W-1:0] weight_idx,
  output logic             tile_done,
  output logic             underrun_err
);

  // wr_cnt must be able to hold BLOCK_SIZE itself, hence one bit wider than the index.
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] WR_FULL_CNT = CNT_W'(BLOCK_SIZE);
  localparam logic [IDX_W-1:0] RD_LAST     = IDX_W'(BLOCK_SIZE - 1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] wr_cnt;
  logic [IDX_W-1:0] rd_cnt;
  logic             rd_loaded;
  logic             wr_full;
  logic             pipe_busy;
  logic [IDX_W:0]   pipe_in;
  logic [IDX_W:0]   pipe_out;

  assign wr_full      = (wr_cnt == WR_FULL_CNT);
  assign src_ready    = buf_in_ready && !wr_full && (state != ST_SWAP);
  assign buf_in_valid = src_valid && src_ready;
  assign buf_swap     = (state == ST_SWAP);
  assign buf_read_en  = (state == ST_STREAM) && !buf_empty;
  assign tile_done    = (state == ST_DRAIN) && !pipe_busy;
  assign block_ready  = rd_loaded;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (wr_full && !rd_loaded)      state_nxt = ST_SWAP;
        else if (rd_loaded && tile_req) state_nxt = ST_STREAM;
      end
      ST_SWAP:   state_nxt = ST_IDLE;
      ST_STREAM: if (buf_read_en && (rd_cnt == RD_LAST)) state_nxt = ST_DRAIN;
      ST_DRAIN:  if (!pipe_busy) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      wr_cnt       <= '0;
      rd_cnt       <= '0;
      rd_loaded    <= 1'b0;
      underrun_err <= 1'b0;
    end else begin
      state <= state_nxt;

      if (state == ST_SWAP)  wr_cnt <= '0;
      else if (buf_in_valid) wr_cnt <= wr_cnt + CNT_W'(1);

      if (buf_read_en) rd_cnt <= (rd_cnt == RD_LAST) ? '0 : rd_cnt + IDX_W'(1);

      if (state == ST_SWAP) rd_loaded <= 1'b1;
      else if (tile_done)   rd_loaded <= 1'b0;

      // Stale beats at swap time or a dry read FIFO mid-block both mean lost weights.
      if (((state == ST_SWAP) && !buf_empty) || ((state == ST_STREAM) && buf_empty))
        underrun_err <= 1'b1;
    end
  end

  assign pipe_in = {buf_read_en, rd_cnt};

  valid_idx_delay #(
    .WIDTH (IDX_W + 1),
    .DEPTH (READ_LATENCY)
  ) u_valid_idx_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (pipe_in),
    .dout  (pipe_out),
    .busy  (pipe_busy)
  );

  assign weight_valid = pipe_out[IDX_W];
  assign weight_idx   = pipe_out[IDX_W-1:0];

endmodule

// File: tb/tb_weight_buffer_ctrl.sv
// Self-checking bench for weight_buffer_ctrl with a count-level model of the weight_buffer.
module tb_weight_buffer_ctrl;

  localparam int BS  = 16;
  localparam int RL  = 1;
  localparam int IW  = $clog2(BS);
  localparam int BIG = 1 << 30;

  typedef struct {
    int due;
    int idx;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          src_valid = 1'b0;
  logic          src_ready;
  logic          buf_in_valid;
  logic          buf_in_ready;
  logic          buf_swap;
  logic          buf_read_en;
  logic          buf_empty;
  logic          tile_req = 1'b0;
  logic          block_ready;
  logic          weight_valid;
  logic [IW-1:0] weight_idx;
  logic          tile_done;
  logic          underrun_err;
  logic          force_empty = 1'b0;

  int wq, rq;
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // expectation model: beats in write side, cycle it filled, cycle read side became free
  int m_acc = 0;
  int m_full = -1;
  int m_free = -10;
  bit m_loaded = 1'b0;
  bit m_err = 1'b0;

  logic s_rdy, s_inv, s_swap, s_rd, s_brdy, s_wv, s_done, s_err;
  logic [IW-1:0] s_idx;

  always #5 clk = ~clk;

  weight_buffer_ctrl #(.BLOCK_SIZE(BS), .READ_LATENCY(RL)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .src_valid    (src_valid),
    .src_ready    (src_ready),
    .buf_in_valid (buf_in_valid),
    .buf_in_ready (buf_in_ready),
    .buf_swap     (buf_swap),
    .buf_read_en  (buf_read_en),
    .buf_empty    (buf_empty),
    .tile_req     (tile_req),
    .block_ready  (block_ready),
    .weight_valid (weight_valid),
    .weight_idx   (weight_idx),
    .tile_done    (tile_done),
    .underrun_err (underrun_err)
  );

  // Occupancy-only model of the double buffer; shares rst_n with the controller.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wq <= 0;
      rq <= 0;
    end else if (buf_swap) begin
      rq <= rq + wq;
      wq <= 0;
    end else begin
      if (buf_in_valid) wq <= wq + 1;
      if (buf_read_en && rq > 0) rq <= rq - 1;
    end
  end

  assign buf_in_ready = rst_n && (wq < BS);
  assign buf_empty    = force_empty || (rq == 0);

  task automatic step(input logic sv, input logic tr, input logic fe);
    src_valid   = sv;
    tile_req    = tr;
    force_empty = fe;
    @(negedge clk);
    cyc++;
    s_rdy  = src_ready;
    s_inv  = buf_in_valid;
    s_swap = buf_swap;
    s_rd   = buf_read_en;
    s_brdy = block_ready;
    s_wv   = weight_valid;
    s_idx  = weight_idx;
    s_done = tile_done;
    s_err  = underrun_err;
    @(posedge clk);
    #1;
  endtask

  function automatic bit swap_due();
    int t;
    t = (m_full > m_free) ? m_full : m_free;
    return (m_acc == BS) && (cyc == t + 2);
  endfunction

  task automatic wr_model(input logic sv, input bit exp_swap, input bit exp_rdy);
    if (sv && exp_rdy) begin
      m_acc++;
      if (m_acc == BS) m_full = cyc;
    end
    if (exp_swap) begin
      m_acc    = 0;
      m_free   = BIG;
      m_loaded = 1'b1;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (src_ready !== 1'b0)    begin errors++; $display("FAIL reset_src_ready: got %b expected 0", src_ready); end
    checks++; if (buf_in_valid !== 1'b0) begin errors++; $display("FAIL reset_in_valid: got %b expected 0", buf_in_valid); end
    checks++; if (buf_swap !== 1'b0)     begin errors++; $display("FAIL reset_swap: got %b expected 0", buf_swap); end
    checks++; if (buf_read_en !== 1'b0)  begin errors++; $display("FAIL reset_read_en: got %b expected 0", buf_read_en); end
    checks++; if (block_ready !== 1'b0)  begin errors++; $display("FAIL reset_block_ready: got %b expected 0", block_ready); end
    checks++; if (weight_valid !== 1'b0) begin errors++; $display("FAIL reset_weight_valid: got %b expected 0", weight_valid); end
    checks++; if (weight_idx !== '0)     begin errors++; $display("FAIL reset_weight_idx: got %0d expected 0", weight_idx); end
    checks++; if (tile_done !== 1'b0)    begin errors++; $display("FAIL reset_tile_done: got %b expected 0", tile_done); end
    checks++; if (underrun_err !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b expected 0", underrun_err); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_load(input int prob, input bit chk17);
    int  c0, swap_cyc, obs_swap;
    bit  sv, exp_swap, exp_rdy;
    c0       = cyc + 1;
    swap_cyc = -1;
    obs_swap = -1;
    for (int k = 0; k < 300 && swap_cyc < 0; k++) begin
      sv = ($urandom_range(99) < prob);
      step(sv, 1'b0, 1'b0);
      exp_swap = swap_due();
      exp_rdy  = (m_acc < BS) && !exp_swap;
      checks++; if (s_swap !== exp_swap) begin errors++; $display("FAIL load_swap @%0d: got %b expected %b", cyc, s_swap, exp_swap); end
      checks++; if (s_rdy !== exp_rdy) begin errors++; $display("FAIL load_src_ready @%0d: got %b expected %b", cyc, s_rdy, exp_rdy); end
      checks++; if (s_inv !== (sv && exp_rdy)) begin errors++; $display("FAIL load_in_valid @%0d: got %b expected %b", cyc, s_inv, sv && exp_rdy); end
      checks++; if (s_brdy !== m_loaded) begin errors++; $display("FAIL load_block_ready @%0d: got %b expected %b", cyc, s_brdy, m_loaded); end
      checks++; if (s_rd !== 1'b0) begin errors++; $display("FAIL load_read_en @%0d: got %b expected 0", cyc, s_rd); end
      if (s_swap && obs_swap < 0) obs_swap = cyc;
      if (exp_swap) swap_cyc = cyc;
      wr_model(sv, exp_swap, exp_rdy);
    end
    checks++; if (swap_cyc < 0) begin errors++; $display("FAIL load_timeout: got no swap expected one"); end
    if (chk17) begin
      checks++; if (obs_swap - c0 !== 17) begin errors++; $display("FAIL load_swap_cycle: got %0d expected 17", obs_swap - c0); end
    end
    step(1'b0, 1'b0, 1'b0);
    exp_rdy = (m_acc < BS) && !swap_due();
    checks++; if (s_rdy !== exp_rdy) begin errors++; $display("FAIL post_swap_src_ready: got %b expected %b", s_rdy, exp_rdy); end
    checks++; if (s_brdy !== m_loaded) begin errors++; $display("FAIL post_swap_block_ready: got %b expected %b", s_brdy, m_loaded); end
    wr_model(1'b0, 1'b0, exp_rdy);
  endtask

  task automatic test_stream(input int stall_at, input int stall_len, input int n_beats, input int prob);
    int   issued, last_rd, stalls, tot, done_cyc;
    bit   fe, sv, streaming, exp_rd, exp_wv, exp_done, exp_swap, exp_rdy;
    exp_t q[$];
    logic [IW-1:0] e_idx;
    issued = 0; last_rd = -1; stalls = 0; tot = 0; done_cyc = -1;
    for (int k = 0; k < 400; k++) begin
      if (done_cyc >= 0 && tot >= n_beats && !(m_acc == BS && m_free < BIG)) break;
      fe = (k >= 1) && (issued == stall_at) && (stalls < stall_len);
      if (fe) stalls++;
      sv = (tot < n_beats) && ($urandom_range(99) < prob);
      step(sv, (k == 0), fe);
      streaming = (k >= 1) && (issued < BS);
      exp_rd    = streaming && !fe;
      exp_wv    = (q.size() > 0) && (q[0].due == cyc);
      exp_done  = (issued == BS) && (cyc == last_rd + RL + 1);
      exp_swap  = swap_due();
      exp_rdy   = (m_acc < BS) && !exp_swap;
      checks++; if (s_rd !== exp_rd) begin errors++; $display("FAIL stream_read_en @%0d: got %b expected %b", cyc, s_rd, exp_rd); end
      checks++; if (s_err !== m_err) begin errors++; $display("FAIL stream_underrun @%0d: got %b expected %b", cyc, s_err, m_err); end
      checks++; if (s_wv !== exp_wv) begin errors++; $display("FAIL stream_weight_valid @%0d: got %b expected %b", cyc, s_wv, exp_wv); end
      if (exp_wv) begin
        e_idx = q[0].idx[IW-1:0];
        checks++; if (s_idx !== e_idx) begin errors++; $display("FAIL stream_weight_idx @%0d: got %0d expected %0d", cyc, s_idx, e_idx); end
        void'(q.pop_front());
      end
      checks++; if (s_done !== exp_done) begin errors++; $display("FAIL stream_tile_done @%0d: got %b expected %b", cyc, s_done, exp_done); end
      checks++; if (s_brdy !== m_loaded) begin errors++; $display("FAIL stream_block_ready @%0d: got %b expected %b", cyc, s_brdy, m_loaded); end
      checks++; if (s_swap !== exp_swap) begin errors++; $display("FAIL stream_swap @%0d: got %b expected %b", cyc, s_swap, exp_swap); end
      checks++; if (s_rdy !== exp_rdy) begin errors++; $display("FAIL stream_src_ready @%0d: got %b expected %b", cyc, s_rdy, exp_rdy); end
      checks++; if (s_inv !== (sv && exp_rdy)) begin errors++; $display("FAIL stream_in_valid @%0d: got %b expected %b", cyc, s_inv, sv && exp_rdy); end
      if (exp_rd) begin
        q.push_back('{due: cyc + RL, idx: issued});
        issued++;
        if (issued == BS) last_rd = cyc;
      end
      if (streaming && fe) m_err = 1'b1;
      if (exp_done) begin
        done_cyc = cyc;
        m_free   = cyc;
        m_loaded = 1'b0;
      end
      if (sv && exp_rdy) tot++;
      wr_model(sv, exp_swap, exp_rdy);
    end
    checks++; if (done_cyc < 0 || tot < n_beats) begin errors++; $display("FAIL stream_timeout: got done_cyc %0d beats %0d expected done and %0d beats", done_cyc, tot, n_beats); end
  endtask

  task automatic test_reset_mid();
    int cnt;
    cnt = 0;
    step(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 40 && cnt < 8; k++) begin
      step(1'b0, 1'b0, 1'b0);
      if (s_rd) cnt++;
    end
    rst_n = 1'b0;
    #1;
    checks++; if (src_ready !== 1'b0)    begin errors++; $display("FAIL midrst_src_ready: got %b expected 0", src_ready); end
    checks++; if (buf_read_en !== 1'b0)  begin errors++; $display("FAIL midrst_read_en: got %b expected 0", buf_read_en); end
    checks++; if (block_ready !== 1'b0)  begin errors++; $display("FAIL midrst_block_ready: got %b expected 0", block_ready); end
    checks++; if (weight_valid !== 1'b0) begin errors++; $display("FAIL midrst_weight_valid: got %b expected 0", weight_valid); end
    checks++; if (weight_idx !== '0)     begin errors++; $display("FAIL midrst_weight_idx: got %0d expected 0", weight_idx); end
    checks++; if (tile_done !== 1'b0)    begin errors++; $display("FAIL midrst_tile_done: got %b expected 0", tile_done); end
    checks++; if (underrun_err !== 1'b0) begin errors++; $display("FAIL midrst_underrun: got %b expected 0", underrun_err); end
    checks++; if (buf_swap !== 1'b0)     begin errors++; $display("FAIL midrst_swap: got %b expected 0", buf_swap); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    m_acc = 0; m_full = -1; m_free = -10; m_loaded = 1'b0; m_err = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load(100, 1'b1);
    test_stream(-1, 0, 0, 0);
    test_load(60, 1'b0);
    test_stream(-1, 0, 32, 100);
    test_stream(5, 3, 0, 0);
    test_stream(-1, 0, 16, 50);
    test_reset_mid();
    test_load(100, 1'b1);
    test_stream(-1, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
